// File: rtl/i2c_led_driver_pkg.sv
// led_driver_pkg: shared widths, register map, MODE bit positions, LEDOUT
// encodings and serial-target FSM states for the i2c_led_driver slice.
package led_driver_pkg;
   localparam int ADDR_BITS = 3;
   localparam int DATA_BITS = 8;
   typedef enum logic [ADDR_BITS-1:0] {
      REG_MODE    = 3'd0,
      REG_PWM0    = 3'd1,
      REG_PWM1    = 3'd2,
      REG_PWM2    = 3'd3,
      REG_PWM3    = 3'd4,
      REG_GRPPWM  = 3'd5,
      REG_GRPFREQ = 3'd6,
      REG_LEDOUT  = 3'd7
   } reg_enum_t;
   localparam int MODE_SLEEP  = 4;
   localparam int MODE_DMBLNK = 3;
   localparam int MODE_INVRT  = 2;
   typedef enum logic [1:0] {
      LED_OFF = 2'b00,
      LED_ON  = 2'b01,
      LED_PWM = 2'b10,
      LED_GRP = 2'b11
   } ledout_t;
   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_REG, ST_WDATA, ST_RDATA, ST_IGNORE
   } state_t;
endpackage

// File: rtl/i2c_led_driver_if.sv
// bus_if: internal register bus between the serial target and the register file.
//   addr  : register select
//   data  : write data, valid with w_en
//   w_en  : one-cycle write strobe
//   rdata : read data for addr, returned by the register file
interface bus_if;
   logic [led_driver_pkg::ADDR_BITS-1:0] addr;
   logic [led_driver_pkg::DATA_BITS-1:0] data;
   logic [led_driver_pkg::DATA_BITS-1:0] rdata;
   logic                                 w_en;
   modport master (output addr, data, w_en, input rdata);
   modport slave  (input addr, data, w_en, output rdata);
endinterface

// File: rtl/i2c_led_driver_ctrl.sv
// i2c_controller: oversampled serial target turning scl/sda transactions into
// register bus writes and reads.
//   clk, reset_n : system clock, async active-low reset
//   scl, sda_i   : raw serial clock and data inputs
//   sda_o, sda_oe: data drive value and enable for read bits
//   bus          : register bus master
module i2c_controller
   import led_driver_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = 7'h40
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   scl,
   input  logic   sda_i,
   output logic   sda_o,
   output logic   sda_oe,
   bus_if.master  bus
);
   // [1] is the synchronized level, [2] the previous one for edge detection
   logic [2:0] scl_q, sda_q;
   logic       scl_r, scl_p, sda_r, sda_p, rise, fall, start, stop;
   state_t     state;
   logic [2:0] cnt;
   logic [6:0] sh;
   logic [7:0] nxt, rd_sh;
   logic       rw, load;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl};
         sda_q <= {sda_q[1:0], sda_i};
      end
   assign scl_r = scl_q[1];
   assign scl_p = scl_q[2];
   assign sda_r = sda_q[1];
   assign sda_p = sda_q[2];
   assign rise  = scl_r & ~scl_p;
   assign fall  = ~scl_r & scl_p;
   assign start = scl_r & scl_p & sda_p & ~sda_r;
   assign stop  = scl_r & scl_p & ~sda_p & sda_r;
   assign nxt   = {sh, sda_r};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         sh       <= '0;
         rd_sh    <= '0;
         rw       <= 1'b0;
         load     <= 1'b0;
         sda_o    <= 1'b1;
         sda_oe   <= 1'b0;
         bus.addr <= '0;
         bus.data <= '0;
         bus.w_en <= 1'b0;
      end else begin
         bus.w_en <= 1'b0;
         if (start) begin
            state  <= ST_ADDR;
            cnt    <= '0;
            sda_oe <= 1'b0;
         end else if (stop) begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
         end else begin
            case (state)
               ST_ADDR, ST_REG, ST_WDATA:
                  if (rise) begin
                     sh  <= nxt[6:0];
                     cnt <= cnt + 3'd1;
                     if (cnt == 3'd7) begin
                        if (state == ST_ADDR) begin
                           rw    <= nxt[0];
                           state <= (nxt[7:1] == I2C_ADDR) ? ST_REG : ST_IGNORE;
                        end else if (state == ST_REG) begin
                           bus.addr <= nxt[ADDR_BITS-1:0];
                           load     <= rw;
                           state    <= rw ? ST_RDATA : ST_WDATA;
                        end else begin
                           bus.data <= nxt;
                           bus.w_en <= 1'b1;
                           state    <= ST_IGNORE;
                        end
                     end
                  end
               ST_RDATA:
                  // rdata is combinational on addr, so it is captured one cycle after addr is set
                  if (load) begin
                     rd_sh <= bus.rdata;
                     load  <= 1'b0;
                  end else if (fall) begin
                     sda_oe <= 1'b1;
                     sda_o  <= rd_sh[7];
                     rd_sh  <= {rd_sh[6:0], 1'b0};
                  end else if (rise) begin
                     cnt <= cnt + 3'd1;
                     if (cnt == 3'd7) begin
                        state  <= ST_IDLE;
                        sda_oe <= 1'b0;
                     end
                  end
               default: ;
            endcase
         end
      end
endmodule

// File: rtl/i2c_led_driver.sv
// i2c_led_driver: four-channel LED PWM driver with a serial register interface.
//   clk, reset_n : system clock, async active-low reset
//   scl, sda     : serial clock in, serial data (driven only during read bits)
//   leds         : registered LED outputs
module i2c_led_driver
   import led_driver_pkg::*;
#(
   parameter int         CLK_HZ     = 1_000_000,
   parameter logic [6:0] I2C_ADDR   = 7'h40,
   parameter int         BLINK_STEP = CLK_HZ / (24 * 256)
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scl,
   inout  wire        sda,
   output logic [3:0] leds
);
   bus_if bus ();
   logic                 sda_o, sda_oe, sleep, dmblnk, inv, grp;
   logic [DATA_BITS-1:0] regs [8];
   logic [1:0]           pre;
   logic [7:0]           cnt, phase;
   logic [31:0]          bcnt, blim;
   logic [3:0]           raw;
   assign sda = sda_oe ? sda_o : 1'bz;
   i2c_controller #(.I2C_ADDR(I2C_ADDR)) u_ctrl (
      .clk    (clk),
      .reset_n(reset_n),
      .scl    (scl),
      .sda_i  (sda),
      .sda_o  (sda_o),
      .sda_oe (sda_oe),
      .bus    (bus.master)
   );
   assign bus.rdata = regs[bus.addr];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         for (int i = 0; i < 8; i++) regs[i] <= (i == int'(REG_GRPPWM)) ? 8'hFF : 8'h00;
      else if (bus.w_en)
         regs[bus.addr] <= bus.data;
   assign sleep  = regs[REG_MODE][MODE_SLEEP];
   assign dmblnk = regs[REG_MODE][MODE_DMBLNK];
   assign inv    = regs[REG_MODE][MODE_INVRT];
   assign blim   = (32'(regs[REG_GRPFREQ]) + 32'd1) * 32'(BLINK_STEP);
   assign grp    = phase < regs[REG_GRPPWM];
   for (genvar i = 0; i < 4; i++) begin : g_led
      logic [1:0] sel;
      logic       ind;
      assign sel    = regs[REG_LEDOUT][2*i +: 2];
      assign ind    = cnt < regs[i+1];
      assign raw[i] = (sel == LED_OFF) ? 1'b0 :
                      (sel == LED_ON)  ? 1'b1 :
                      (sel == LED_PWM) ? ind  : ind & grp;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         pre   <= '0;
         cnt   <= '0;
         phase <= '0;
         bcnt  <= '0;
         leds  <= '0;
      end else begin
         if (!sleep) begin
            pre <= pre + 2'd1;
            if (pre == 2'd3) cnt <= cnt + 8'd1;
            // >= keeps the blink divider bounded when GRPFREQ is lowered mid-count
            if (dmblnk) begin
               if (bcnt >= blim - 32'd1) begin
                  bcnt  <= '0;
                  phase <= phase + 8'd1;
               end else
                  bcnt <= bcnt + 32'd1;
            end else if (pre == 2'd3 && cnt == 8'hFF)
               phase <= phase + 8'd1;
         end
         leds <= sleep ? 4'b0000 : raw ^ {4{inv}};
      end
endmodule

// File: tb/tb_i2c_led_driver.sv
// tb_i2c_led_driver: directed register writes/reads over the serial link with
// duty-cycle measurements on the LED outputs.
module tb_i2c_led_driver;
   localparam int H = 10;
   logic       clk = 1'b0, reset_n = 1'b0, scl = 1'b1, host_drv = 1'b1, host_val = 1'b1;
   wire        sda;
   logic [3:0] leds;
   int         total = 0, bad = 0, cyc = 0, rise_cyc = 0, wen_cnt = 0, wen_lat = 0;
   int         hi [4];
   logic [2:0] wen_addr;
   logic [7:0] wen_data, rd;
   assign sda = host_drv ? host_val : 1'bz;
   always #5 clk = ~clk;
   i2c_led_driver #(.BLINK_STEP(1)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .scl    (scl),
      .sda    (sda),
      .leds   (leds)
   );
   always @(posedge clk) cyc++;
   always @(negedge clk)
      if (dut.bus.w_en) begin
         wen_cnt++;
         wen_addr = dut.bus.addr;
         wen_data = dut.bus.data;
         wen_lat  = cyc - rise_cyc;
      end
   initial begin
      #2ms;
      $display("FAIL timeout");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         tick(H/2);
         host_val = b[i];
         tick(H/2);
         scl = 1'b1;
         rise_cyc = cyc;
         tick(H);
         scl = 1'b0;
      end
   endtask
   task automatic i2c_start();
      host_val = 1'b1;
      scl = 1'b1;
      tick(H);
      host_val = 1'b0;
      tick(H);
      scl = 1'b0;
   endtask
   task automatic i2c_stop();
      tick(H/2);
      host_val = 1'b0;
      tick(H/2);
      scl = 1'b1;
      tick(H);
      host_val = 1'b1;
      tick(H);
   endtask
   task automatic wr(input logic [2:0] r, input logic [7:0] d);
      i2c_start();
      send_byte(8'h80);
      send_byte({5'd0, r});
      send_byte(d);
      tick(4);
      i2c_stop();
   endtask
   task automatic rd_reg(input logic [2:0] r, output logic [7:0] d);
      i2c_start();
      send_byte(8'h81);
      send_byte({5'd0, r});
      tick(H/2);
      host_drv = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         tick(H/2);
         scl = 1'b1;
         tick(1);
         d[i] = sda;
         if (i == 0) begin
            host_val = sda;
            host_drv = 1'b1;
         end
         tick(H-1);
         scl = 1'b0;
      end
      i2c_stop();
   endtask
   task automatic measure(input int n);
      hi = '{0, 0, 0, 0};
      repeat (n) begin
         @(negedge clk);
         for (int j = 0; j < 4; j++) hi[j] += int'(leds[j]);
      end
      tick(1);
   endtask
   initial begin
      int exp_duty [4];
      logic [7:0] exp_pwm [4];
      tick(3);
      chk("rst_leds", leds, 4'h0);
      reset_n = 1'b1;
      tick(5);
      rd_reg(3'd5, rd);
      chk("rst_grppwm", rd, 8'hFF);
      rd_reg(3'd7, rd);
      chk("rst_ledout", rd, 8'h00);
      wen_cnt = 0;
      wr(3'd7, 8'h55);
      chk("wen_cnt", wen_cnt, 1);
      chk("wen_addr", wen_addr, 3'd7);
      chk("wen_data", wen_data, 8'h55);
      chk("wen_lat", wen_lat <= 4, 1);
      tick(2);
      measure(1024);
      for (int j = 0; j < 4; j++) chk($sformatf("on%0d", j), hi[j], 1024);
      wr(3'd1, 8'h40);
      wr(3'd2, 8'h80);
      wr(3'd3, 8'hC0);
      wr(3'd4, 8'hFF);
      wr(3'd7, 8'hAA);
      tick(8);
      measure(1024);
      exp_duty = '{256, 512, 768, 1020};
      for (int j = 0; j < 4; j++) chk($sformatf("duty%0d", j), hi[j], exp_duty[j]);
      wr(3'd2, 8'h01);
      measure(1024);
      chk("duty_min", hi[1], 4);
      wr(3'd1, 8'hFF);
      wr(3'd5, 8'h00);
      wr(3'd7, 8'hFF);
      measure(1024);
      for (int j = 0; j < 4; j++) chk($sformatf("grp0_%0d", j), hi[j], 0);
      wr(3'd5, 8'hFF);
      measure(1024);
      chk("grp_full", hi[0], 1020);
      wr(3'd7, 8'h03);
      wr(3'd6, 8'h10);
      wr(3'd5, 8'h80);
      wr(3'd0, 8'h08);
      tick(100);
      measure(17408);
      chk("blink17", hi[0] >= 8636 && hi[0] <= 8704, 1);
      chk("blink17_off", hi[1], 0);
      wr(3'd6, 8'h01);
      tick(100);
      measure(1024);
      chk("blink2", hi[0] >= 508 && hi[0] <= 512, 1);
      wr(3'd0, 8'h00);
      wr(3'd7, 8'h55);
      wr(3'd0, 8'h10);
      tick(4);
      measure(256);
      chk("sleep", hi[0] + hi[1] + hi[2] + hi[3], 0);
      wr(3'd0, 8'h04);
      measure(256);
      chk("invrt_on", hi[0] + hi[1] + hi[2] + hi[3], 0);
      wr(3'd7, 8'h00);
      measure(256);
      chk("invrt_off", hi[0] + hi[1] + hi[2] + hi[3], 1024);
      wr(3'd0, 8'h14);
      measure(256);
      chk("sleep_invrt", hi[0] + hi[1] + hi[2] + hi[3], 0);
      wr(3'd0, 8'h00);
      wr(3'd7, 8'h55);
      measure(256);
      chk("normal", hi[0] + hi[1] + hi[2] + hi[3], 1024);
      exp_pwm = '{8'hFF, 8'h01, 8'hC0, 8'hFF};
      for (int j = 0; j < 4; j++) begin
         rd_reg(3'(j + 1), rd);
         chk($sformatf("rd_pwm%0d", j), rd, exp_pwm[j]);
      end
      wen_cnt = 0;
      i2c_start();
      send_byte(8'h82);
      send_byte(8'h01);
      send_byte(8'h33);
      tick(4);
      i2c_stop();
      chk("bad_addr_wen", wen_cnt, 0);
      rd_reg(3'd1, rd);
      chk("bad_addr_pwm0", rd, 8'hFF);
      tick(10);
      reset_n = 1'b0;
      #2;
      chk("rst_async", leds, 4'h0);
      tick(2);
      reset_n = 1'b1;
      tick(4);
      for (int j = 0; j < 4; j++) begin
         rd_reg(3'(j + 1), rd);
         chk($sformatf("rst_pwm%0d", j), rd, 8'h00);
      end
      rd_reg(3'd5, rd);
      chk("rst_grppwm2", rd, 8'hFF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/i2c_led_driver.md
# i2c_led_driver

Four-channel LED PWM driver controlled over a minimal I2C-style serial link, in the style of a PCA9633. A serial target decodes register write/read transactions into an internal register bus; a PWM engine drives four LED outputs from those registers. It sits at the board edge: `scl`/`sda` from the host, `leds` to the LED pins.

## Interface
- `CLK_HZ`, 1_000_000: `clk` frequency; must be ≥ 20× SCL rate.
- `I2C_ADDR`, 7'h40: 7-bit device address.
- `BLINK_STEP`, CLK_HZ/(24*256): clk cycles per blink phase step.
- `clk` in 1: the single clock, used for all logic; SCL is sampled, never used as a clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `scl` in 1: serial clock from host.
- `sda` inout 1: serial data; tri-stated except during read data bits.
- `leds` out 4: LED outputs, registered; 0 at reset.

## Operation
- Registers (8-bit, addr 3-bit), reset values: MODE=0 0x00, PWM0..PWM3=1..4 0x00, GRPPWM=5 0xFF, GRPFREQ=6 0x00, LEDOUT=7 0x00.
- MODE bits: [4] SLEEP, [3] DMBLNK, [2] INVRT; other bits read back as written, no effect.
- `scl`/`sda` pass 2-flop synchronizers; edges are detected in clk domain.
- START: sda falls while scl high; STOP: sda rises while scl high. Either, at any point, returns the FSM to the start of a transaction (START → ADDR, STOP → IDLE).
- FSM: IDLE → ADDR (8 bits) → REG (8 bits) → WDATA or RDATA (8 bits) → IDLE. Bits MSB first, sampled on scl rising edge. No ACK cycles.
- ADDR byte {addr7, rw}: mismatch → IGNORE until next START/STOP.
- REG byte: bits [2:0] select register; [7:3] ignored.
- Write (rw=0): after 8th WDATA bit, one-cycle pulse on internal `bus.w_en` with `bus.addr`, `bus.data`; register updates on that cycle. Extra bytes ignored.
- Read (rw=1): register value latched at end of REG byte; target drives `sda` (both levels actively) from each scl falling edge during RDATA, MSB first, so the bit is stable at the next rising edge. Releases `sda` after 8th bit or on START/STOP.
- PWM counter: 8-bit, +1 per clk/4, wraps. ind[i] = cnt < PWMi (0x00 → 0%, 0xFF → 255/256).
- Group counter: 8-bit phase. DMBLNK=0: +1 per PWM counter wrap. DMBLNK=1: +1 every (GRPFREQ+1)·BLINK_STEP clk, giving period (GRPFREQ+1)/24 s. grp = phase < GRPPWM.
- LEDOUT[2i+1:2i] for LED i: 00 off, 01 on, 10 ind[i], 11 ind[i]&grp.
- INVRT=1 inverts all four outputs. SLEEP=1 forces `leds`=0 regardless of INVRT and holds counters.

## Timing
- `leds` registered, one clk after the PWM/group decision.
- Write visible on `bus` ≤ 4 clk after the 8th data scl rising edge, before STOP.
- Register change takes effect at next counter compare; no wait for counter wrap.
- Async reset mid-transaction: FSM → IDLE, `sda` released, registers and counters to reset values, `leds`=0 immediately.

## Structure
- Package `led_driver_pkg`: ADDR_BITS=3, DATA_BITS=8, `reg_enum_t` (REG_MODE, REG_PWM0–3, REG_GRPPWM, REG_GRPFREQ, REG_LEDOUT, values above), MODE bit indices, LEDOUT encodings.
- Interface `bus_if` (addr, data, w_en, rdata) instanced as `bus` inside the top.
- Sub-module `i2c_controller`: synchronizers, START/STOP detect, FSM, sda drive. Register file and PWM engine stay in the top.

## Test plan
- Write LEDOUT=0x55 → `bus` shows addr 7 data 0x55; `leds`=4'b1111 steady.
- LEDOUT=0xAA, PWM0..3=0x40/0x80/0xC0/0xFF → LED duties 25/50/75/99.6%; PWM1=0x01 → 0.4%.
- LEDOUT=0xFF, PWM0=0xFF, GRPPWM=0x00 → all LEDs 0; GRPPWM=0x80 → LED0 gated ~50%.
- MODE=0x08, GRPPWM=0x80, GRPFREQ=0x10 → blink period 708 ms at 50% duty; GRPFREQ=0xFF → 10.67 s.
- MODE=0x10 → `leds`=0; MODE=0x04 → outputs inverted; MODE=0x00 → normal.
- Read PWM0..3 after writes → exact values; pulse reset_n → all read 0x00; wrong address 0x41 → no `bus.w_en`.
